// File: rtl/lcd_char_responder.sv
// Responder for a 4-bit HD44780-style LCD bus: syncs the strobe, walks the power-on sequence, assembles bytes, tracks busy/DDRAM.
// Latency: 3 edges from E fall to strobe detection, byte/address/busy outputs update on the 4th edge.
// Backpressure: none; strobes during busy are still processed but raise the sticky violation flag.
module lcd_char_responder #(
    parameter int SHORT_BUSY_CYCLES = 2000,
    parameter int LONG_BUSY_CYCLES  = 82000,
    parameter int EN_MIN_CYCLES     = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic [3:0] iLCD_Data,
    output logic [7:0] oByte,
    output logic       oByteRS,
    output logic       oByteValid,
    output logic       oInitDone,
    output logic       oBusy,
    output logic [6:0] oDdramAddr,
    output logic       oViolation
);

    localparam int BUSY_MAX = (LONG_BUSY_CYCLES > SHORT_BUSY_CYCLES) ? LONG_BUSY_CYCLES : SHORT_BUSY_CYCLES;
    localparam int BUSY_W   = $clog2(BUSY_MAX + 1);
    localparam int EN_W     = $clog2(EN_MIN_CYCLES + 1);
    localparam logic [EN_W-1:0]   EN_MIN     = EN_W'(EN_MIN_CYCLES);
    localparam logic [BUSY_W-1:0] BUSY_SHORT = BUSY_W'(SHORT_BUSY_CYCLES);
    localparam logic [BUSY_W-1:0] BUSY_LONG  = BUSY_W'(LONG_BUSY_CYCLES);

    typedef enum logic [1:0] {
        STATE_POWERON,
        STATE_HIGH_NIBBLE,
        STATE_LOW_NIBBLE
    } state_t;

    // synchronizer: {E, RS, RW, D[3:0]}
    logic [6:0] r_meta;
    logic [6:0] r_sync;
    logic       w_e;
    logic       w_rs;
    logic       w_rw;
    logic [3:0] w_nib;

    // edge detect and width measurement
    logic            r_e_prev;
    logic [EN_W-1:0] r_en_cnt;
    logic            r_det;
    logic            r_det_bad;
    logic            r_det_rs;
    logic [3:0]      r_det_nib;

    // protocol state
    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_init_cnt;
    logic [1:0]          w_init_cnt_nxt;
    logic [3:0]          r_hi_nib;
    logic                r_hi_rs;
    logic                r_id_inc;
    logic [6:0]          r_addr;
    logic [BUSY_W-1:0]   r_busy_cnt;
    logic [7:0]          r_byte;
    logic                r_byte_rs;
    logic                r_byte_vld;
    logic                r_viol;

    logic       w_hi_ld;
    logic       w_emit;
    logic       w_viol_set;
    logic       w_busy;
    logic [7:0] w_byte;
    logic       w_is_clear;
    logic       w_is_home;

    assign w_e    = r_sync[6];
    assign w_rs   = r_sync[5];
    assign w_rw   = r_sync[4];
    assign w_nib  = r_sync[3:0];
    assign w_busy = (r_busy_cnt != '0);
    assign w_byte = {r_hi_nib, r_det_nib};
    assign w_is_clear = (w_byte == 8'h01);
    assign w_is_home  = (w_byte[7:1] == 7'b0000001);

    // two-flop synchronizer on every bus input
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data};
            r_sync <= r_meta;
        end
    end

    // measure E-high width and register falling-edge detection with its qualifiers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_e_prev  <= 1'b0;
            r_en_cnt  <= '0;
            r_det     <= 1'b0;
            r_det_bad <= 1'b0;
            r_det_rs  <= 1'b0;
            r_det_nib <= '0;
        end else begin
            r_e_prev <= w_e;
            if (w_e) begin
                if (!r_e_prev)
                    r_en_cnt <= EN_W'(1);
                else if (r_en_cnt != EN_MIN)
                    r_en_cnt <= r_en_cnt + EN_W'(1);
            end
            r_det     <= ~w_e & r_e_prev;
            r_det_bad <= (r_en_cnt < EN_MIN) | w_rw;
            r_det_rs  <= w_rs;
            r_det_nib <= w_nib;
        end
    end

    // next-state logic: power-on sequence, nibble pairing and violation sources
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_hi_ld        = 1'b0;
        w_emit         = 1'b0;
        w_viol_set     = 1'b0;
        if (r_det) begin
            if (r_det_bad) begin
                w_viol_set = 1'b1;
            end else begin
                case (r_state)
                    STATE_POWERON: begin
                        if (!r_det_rs && r_det_nib == 4'h3) begin
                            if (r_init_cnt != 2'd3)
                                w_init_cnt_nxt = r_init_cnt + 2'd1;
                        end else if (!r_det_rs && r_det_nib == 4'h2 && r_init_cnt == 2'd3) begin
                            w_state_nxt = STATE_HIGH_NIBBLE;
                        end else begin
                            w_viol_set     = 1'b1;
                            w_init_cnt_nxt = 2'd0;
                        end
                    end
                    STATE_HIGH_NIBBLE: begin
                        w_hi_ld     = 1'b1;
                        w_viol_set  = w_busy;
                        w_state_nxt = STATE_LOW_NIBBLE;
                    end
                    STATE_LOW_NIBBLE: begin
                        w_state_nxt = STATE_HIGH_NIBBLE;
                        if (r_det_rs == r_hi_rs)
                            w_emit = 1'b1;
                        w_viol_set = w_busy | (r_det_rs != r_hi_rs);
                    end
                    default: w_state_nxt = STATE_POWERON;
                endcase
            end
        end
    end

    // state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= STATE_POWERON;
            r_init_cnt <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // byte assembly, decode of emitted bytes, busy counter and sticky violation
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_hi_nib   <= '0;
            r_hi_rs    <= 1'b0;
            r_id_inc   <= 1'b1;
            r_addr     <= '0;
            r_busy_cnt <= '0;
            r_byte     <= '0;
            r_byte_rs  <= 1'b0;
            r_byte_vld <= 1'b0;
            r_viol     <= 1'b0;
        end else begin
            r_byte_vld <= w_emit;
            if (w_viol_set)
                r_viol <= 1'b1;
            if (w_hi_ld) begin
                r_hi_nib <= r_det_nib;
                r_hi_rs  <= r_det_rs;
            end
            if (w_emit) begin
                r_byte     <= w_byte;
                r_byte_rs  <= r_hi_rs;
                r_busy_cnt <= BUSY_SHORT;
                if (r_hi_rs) begin
                    r_addr <= r_id_inc ? r_addr + 7'd1 : r_addr - 7'd1;
                end else if (w_is_clear) begin
                    r_addr     <= '0;
                    r_id_inc   <= 1'b1;
                    r_busy_cnt <= BUSY_LONG;
                end else if (w_is_home) begin
                    r_addr     <= '0;
                    r_busy_cnt <= BUSY_LONG;
                end else if (w_byte[7:2] == 6'b000001) begin
                    r_id_inc <= w_byte[1];
                end else if (w_byte[7]) begin
                    r_addr <= w_byte[6:0];
                end
            end else if (w_busy) begin
                r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
            end
        end
    end

    assign oByte      = r_byte;
    assign oByteRS    = r_byte_rs;
    assign oByteValid = r_byte_vld;
    assign oInitDone  = (r_state != STATE_POWERON);
    assign oBusy      = w_busy;
    assign oDdramAddr = r_addr;
    assign oViolation = r_viol;

endmodule
